// File: rtl/dmi_dtm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_dtm_ctrl
//  Description : DTM data-register logic between the JTAG TAP and the DMI
//                request/response channel. Holds DTMCS and the DMI DR, runs
//                the request FSM, and times out stalled responses. Late
//                responses after a timeout are drained. TCK domain only.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmi_dtm_ctrl #(
  parameter int unsigned ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tap_reset_i,
  input  logic               capture_i,
  input  logic               shift_i,
  input  logic               update_i,
  input  logic               tdi_i,
  input  logic               dtmcs_select_i,
  input  logic               dmi_select_i,
  output logic               dtmcs_tdo_o,
  output logic               dmi_tdo_o,
  output logic               dmi_clear_o,
  output logic [ABITS+33:0]  dmi_req_o,
  output logic               dmi_req_valid_o,
  input  logic               dmi_req_ready_i,
  input  logic [33:0]        dmi_resp_i,
  input  logic               dmi_resp_valid_i,
  output logic               dmi_resp_ready_o,
  output logic               timeout_o
);

  localparam int unsigned        DRW     = ABITS + 34;
  localparam bit                 TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [1:0]         ERR_FAIL = 2'd2;
  localparam logic [1:0]         ERR_BUSY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_RD  = 3'd1,
    S_WAIT_RD = 3'd2,
    S_REQ_WR  = 3'd3,
    S_WAIT_WR = 3'd4,
    S_DRAIN   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        dtmcs_q, dtmcs_d;
  logic [DRW-1:0]     dr_q, dr_d;
  logic [ABITS-1:0]   addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         error_q, error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic dtmcs_upd;
  logic dmi_upd;
  logic busy_state;
  logic is_wait;
  logic timeout_hit;
  logic set_busy;
  logic set_fail;

  assign dtmcs_upd   = dtmcs_select_i & update_i;
  assign dmi_upd     = dmi_select_i & update_i;
  assign dmi_clear_o = tap_reset_i | (dtmcs_upd & dtmcs_q[17]);
  // A read in flight (or a drain) makes captured DMI data meaningless.
  assign busy_state  = (state_q == S_REQ_RD) | (state_q == S_WAIT_RD) | (state_q == S_DRAIN);
  assign is_wait     = (state_q == S_WAIT_RD) | (state_q == S_WAIT_WR);
  // A response on the deadline cycle takes precedence over the timeout.
  assign timeout_hit = TO_EN & is_wait & ~dmi_resp_valid_i & (cnt_q == TO_LAST);

  assign dtmcs_tdo_o      = dtmcs_q[0];
  assign dmi_tdo_o        = dr_q[0];
  assign dmi_resp_ready_o = 1'b1;
  assign dmi_req_o        = {addr_q, data_q,
                             ((state_q == S_REQ_WR) | (state_q == S_WAIT_WR)) ? 2'd2 : 2'd1};

  // Next-state logic: scan registers, request FSM, sticky error and clear.
  always_comb begin
    state_d         = state_q;
    dtmcs_d         = dtmcs_q;
    dr_d            = dr_q;
    addr_d          = addr_q;
    data_d          = data_q;
    error_d         = error_q;
    cnt_d           = cnt_q;
    set_busy        = 1'b0;
    set_fail        = 1'b0;
    timeout_o       = 1'b0;
    dmi_req_valid_o = 1'b0;

    if (dtmcs_select_i) begin
      if (capture_i) begin
        dtmcs_d = {14'd0, 3'd0, IDLE_HINT, error_q, 6'(ABITS), 4'd1};
      end else if (shift_i) begin
        dtmcs_d = {tdi_i, dtmcs_q[31:1]};
      end
    end

    if (dmi_select_i) begin
      if (capture_i) begin
        dr_d     = {addr_q, data_q, ((error_q == ERR_BUSY) | busy_state) ? ERR_BUSY : error_q};
        set_busy = busy_state;
      end else if (shift_i) begin
        dr_d = {tdi_i, dr_q[DRW-1:1]};
      end else if (update_i && (state_q != S_IDLE)) begin
        set_busy = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (dmi_upd && (error_q == 2'd0)) begin
          addr_d = dr_q[DRW-1:34];
          data_d = dr_q[33:2];
          if (dr_q[1:0] == 2'd1) begin
            state_d = S_REQ_RD;
          end else if (dr_q[1:0] == 2'd2) begin
            state_d = S_REQ_WR;
          end
        end
      end
      S_REQ_RD, S_REQ_WR: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          state_d = (state_q == S_REQ_RD) ? S_WAIT_RD : S_WAIT_WR;
          cnt_d   = '0;
        end
      end
      S_WAIT_RD: begin
        if (dmi_resp_valid_i) begin
          state_d = S_IDLE;
          case (dmi_resp_i[1:0])
            2'd0: data_d = dmi_resp_i[33:2];
            2'd1: data_d = 32'hBAADC0DE;
            2'd2: begin data_d = 32'hDEADBEEF; set_fail = 1'b1; end
            default: begin data_d = 32'hB051B051; set_busy = 1'b1; end
          endcase
        end else if (timeout_hit) begin
          timeout_o = 1'b1;
          set_fail  = 1'b1;
          data_d    = 32'hDEADBEEF;
          state_d   = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_WR: begin
        if (dmi_resp_valid_i) begin
          state_d = S_IDLE;
          if (dmi_resp_i[1:0] == 2'd2) set_fail = 1'b1;
          if (dmi_resp_i[1:0] == 2'd3) set_busy = 1'b1;
        end else if (timeout_hit) begin
          timeout_o = 1'b1;
          set_fail  = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dmi_resp_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Sticky error: first event wins, op-failed beats busy in the same cycle.
    if (error_q == 2'd0) begin
      if (set_fail) begin
        error_d = ERR_FAIL;
      end else if (set_busy) begin
        error_d = ERR_BUSY;
      end
    end
    if (dtmcs_upd && dtmcs_q[16]) error_d = 2'd0;

    if (dmi_clear_o) begin
      state_d = S_IDLE;
      dr_d    = '0;
      addr_d  = '0;
      data_d  = '0;
      error_d = 2'd0;
      cnt_d   = '0;
    end
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      dtmcs_q <= '0;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dtmcs_q <= dtmcs_d;
      dr_q    <= dr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire
